sha256_w_window_feeder: RTL and testbench

Sequential SHA-256 message-schedule source. It accepts one 512-bit message block as 16 serial 32-bit words, holds them in a 16-word sliding window, and streams W0..W63 to the compression-round pipeline through a valid/ready handshake. It is the producer end of the schedule interface: it builds and advances the 16-word window that the per-round schedule stages consume, and it computes each new word internally.

---
 rtl/sha256_w_window_feeder_if.sv | 23 ++
 rtl/sha256_w_window_feeder.sv | 112 +++++++++++
 tb/tb_sha256_w_window_feeder.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_w_window_feeder_if.sv
// Handshake bundle between the SHA-256 schedule feeder and its neighbours:
// the message-word input channel and the W_t output channel.
// slave  = the feeder itself; master = the environment driving it.
interface sha256_w_window_feeder_if;
  logic        msg_valid;
  logic        msg_ready;
  logic [31:0] msg_word;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [5:0]  w_index;
  logic        w_last;

  modport master (
    output msg_valid, msg_word, w_ready,
    input  msg_ready, w_valid, w_data, w_index, w_last
  );

  modport slave (
    input  msg_valid, msg_word, w_ready,
    output msg_ready, w_valid, w_data, w_index, w_last
  );
endinterface

// File: rtl/sha256_w_window_feeder.sv
// SHA-256 message-schedule source. Collects 16 message words into a 16-word
// sliding window, then streams W0..W63 one per accepted handshake, generating
// each new word from the window as the oldest word leaves.
// Optional feature macro: SHA256_W_PARALLEL_LOAD_EN adds block_load/block_in
// for a single-cycle 512-bit window load.
//
// state  | meaning
// S_LOAD | accepting message words, w_valid low
// S_EMIT | presenting window[w1] as W_t, msg_ready low
module sha256_w_window_feeder (
  input  logic                    CLK,
  input  logic                    RST,
`ifdef SHA256_W_PARALLEL_LOAD_EN
  input  logic                    block_load,
  input  logic [511:0]            block_in,
`endif
  sha256_w_window_feeder_if.slave bus
);

  typedef enum logic {S_LOAD, S_EMIT} state_t;

  state_t       state_q, state_d;
  logic [511:0] window_q, window_d;
  logic [3:0]   load_cnt_q, load_cnt_d;
  logic [5:0]   out_idx_q, out_idx_d;
  logic         msg_ready_c;
  logic         pl_take;
  logic [31:0]  w1, w2, w10, w15;
  logic [31:0]  next_word;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // w1 is the oldest window word (W_t), w16 the newest
  assign w1  = window_q[511:480];
  assign w2  = window_q[479:448];
  assign w10 = window_q[223:192];
  assign w15 = window_q[63:32];

  // W_{t+16}; still computed past t=48 even though those words are never shown
  assign next_word = sig0(w2) + w10 + sig1(w15) + w1;

`ifdef SHA256_W_PARALLEL_LOAD_EN
  assign pl_take = (state_q == S_LOAD) && (load_cnt_q == 4'd0) && block_load;
`else
  assign pl_take = 1'b0;
`endif

  // State and datapath registers; reset discards any partial block
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_LOAD;
      window_q   <= '0;
      load_cnt_q <= '0;
      out_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      window_q   <= window_d;
      load_cnt_q <= load_cnt_d;
      out_idx_q  <= out_idx_d;
    end
  end

  // Next-state, window update and input-side ready decode
  always_comb begin
    state_d     = state_q;
    window_d    = window_q;
    load_cnt_d  = load_cnt_q;
    out_idx_d   = out_idx_q;
    msg_ready_c = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        msg_ready_c = !pl_take;
        if (pl_take) begin
`ifdef SHA256_W_PARALLEL_LOAD_EN
          window_d = block_in;
`endif
          out_idx_d = 6'd0;
          state_d   = S_EMIT;
        end else if (bus.msg_valid) begin
          window_d   = {window_q[479:0], bus.msg_word};
          load_cnt_d = load_cnt_q + 4'd1;
          if (load_cnt_q == 4'd15) begin
            load_cnt_d = 4'd0;
            out_idx_d  = 6'd0;
            state_d    = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (bus.w_ready) begin
          window_d  = {window_q[479:0], next_word};
          out_idx_d = out_idx_q + 6'd1;
          if (out_idx_q == 6'd63) state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign bus.msg_ready = msg_ready_c;
  assign bus.w_valid   = (state_q == S_EMIT);
  assign bus.w_data    = w1;
  assign bus.w_index   = out_idx_q;
  assign bus.w_last    = (state_q == S_EMIT) && (out_idx_q == 6'd63);

endmodule

// File: tb/tb_sha256_w_window_feeder.sv
// Bench for sha256_w_window_feeder: scoreboard of expected W_t words built
// from an independent schedule model, plus a spot table for the "abc" block.
module tb_sha256_w_window_feeder;

  typedef logic [31:0] blk_t [16];
  typedef struct { logic [31:0] data; int idx; } exp_t;
  typedef struct { bit is_in; logic [31:0] msg; int idx; logic [31:0] w; } vec_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  sha256_w_window_feeder_if bus();

`ifdef SHA256_W_PARALLEL_LOAD_EN
  logic         block_load = 1'b0;
  logic [511:0] block_in   = '0;
`endif

  sha256_w_window_feeder dut (
    .CLK        (CLK),
    .RST        (RST),
`ifdef SHA256_W_PARALLEL_LOAD_EN
    .block_load (block_load),
    .block_in   (block_in),
`endif
    .bus        (bus)
  );

  always #5 CLK = ~CLK;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  exp_t        exp_q [$];
  logic [31:0] cap [64];
  int          last63_cyc = -1;
  int          gap_meas   = -1;
  bit          chk_ready_next = 1'b0;
  bit          prev_bp = 1'b0;
  bit          prev_wv = 1'b0;
  logic [31:0] prev_data;
  logic [5:0]  prev_idx;
  logic        prev_last;
  exp_t        mon_e;
  vec_t        vecs [18];
  blk_t        abc, blk2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic expect_block(input blk_t b);
    logic [31:0] w [64];
    exp_t e;
    for (int t = 0; t < 16; t++) w[t] = b[t];
    for (int t = 16; t < 64; t++) w[t] = ss1(w[t-2]) + w[t-7] + ss0(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) begin
      e.data = w[t];
      e.idx  = t;
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_cap();
    for (int i = 0; i < 64; i++) cap[i] = 32'hBAD0BAD0;
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge
  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      exp_q.delete();
      prev_bp = 1'b0;
      prev_wv = 1'b0;
      chk_ready_next = 1'b0;
    end else begin
      check_bit("ready_valid_exclusive", bus.msg_ready & bus.w_valid, 1'b0);
      if (chk_ready_next) begin
        check_bit("msg_ready_after_last", bus.msg_ready, 1'b1);
        chk_ready_next = 1'b0;
      end
      if (prev_bp) begin
        check("hold_data", bus.w_data, prev_data);
        check("hold_index", 32'(bus.w_index), 32'(prev_idx));
        check_bit("hold_last", bus.w_last, prev_last);
      end
      if (bus.w_valid && !prev_wv && last63_cyc >= 0) gap_meas = cyc - last63_cyc;
      if (bus.w_valid && bus.w_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_w: got index %0d data 0x%08h required no word", bus.w_index, bus.w_data);
        end else begin
          mon_e = exp_q.pop_front();
          check($sformatf("w_data_t%0d", mon_e.idx), bus.w_data, mon_e.data);
          check($sformatf("w_index_t%0d", mon_e.idx), 32'(bus.w_index), 32'(mon_e.idx));
          check_bit($sformatf("w_last_t%0d", mon_e.idx), bus.w_last, mon_e.idx == 63);
          cap[bus.w_index] = bus.w_data;
          if (mon_e.idx == 63) begin
            last63_cyc = cyc;
            chk_ready_next = 1'b1;
          end
        end
      end
      prev_bp   = bus.w_valid && !bus.w_ready;
      prev_wv   = bus.w_valid;
      prev_data = bus.w_data;
      prev_idx  = bus.w_index;
      prev_last = bus.w_last;
    end
  end

  task automatic send_words(input blk_t b, input int first, input int count, input int gap);
    bit acc;
    int n;
    for (int i = first; i < first + count; i++) begin
      if (i > first) begin
        for (int g = 0; g < gap; g++) begin
          bus.msg_valid = 1'b0;
          @(negedge CLK);
          check_bit("gap_w_valid_low", bus.w_valid, 1'b0);
          @(posedge CLK); #1;
        end
      end
      bus.msg_valid = 1'b1;
      bus.msg_word  = b[i];
      acc = 1'b0;
      n = 0;
      while (!acc && n < 200) begin
        @(negedge CLK);
        acc = bus.msg_ready;
        n++;
      end
      if (!acc) begin
        total++;
        bad++;
        $display("FAIL msg_accept_timeout: word %0d not accepted, required within 200 cycles", i);
        bus.msg_valid = 1'b0;
        return;
      end
      @(posedge CLK); #1;
    end
    bus.msg_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge CLK); #1;
  endtask

  task automatic wait_index(input int idx);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < 300) begin
      @(negedge CLK);
      hit = bus.w_valid && (bus.w_index == 6'(idx));
      n++;
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL wait_index_timeout: index %0d never shown, required within 300 cycles", idx);
    end
  endtask

  task automatic verify_table(input string tag);
    for (int i = 0; i < 18; i++)
      check($sformatf("%s_W%0d", tag, vecs[i].idx), cap[vecs[i].idx], vecs[i].w);
  endtask

  task automatic check_reset_vals(input string tag);
    check_bit({tag, "_msg_ready"}, bus.msg_ready, 1'b1);
    check_bit({tag, "_w_valid"}, bus.w_valid, 1'b0);
    check({tag, "_w_data"}, bus.w_data, 32'h0);
    check({tag, "_w_index"}, 32'(bus.w_index), 32'h0);
    check_bit({tag, "_w_last"}, bus.w_last, 1'b0);
  endtask

  task automatic pulse_reset(input string tag);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check_reset_vals(tag);
    @(posedge CLK); #1;
  endtask

  task automatic run_abc(input string tag, input int gap, input bit bp);
    clear_cap();
    expect_block(abc);
    send_words(abc, 0, 16, gap);
    if (bp) begin
      wait_index(15);
      @(posedge CLK); #1;
      bus.w_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge CLK);
        check_bit("bp_w_valid", bus.w_valid, 1'b1);
        check("bp_w_data", bus.w_data, 32'h61626380);
        check("bp_w_index", 32'(bus.w_index), 32'd16);
      end
      @(posedge CLK); #1;
      bus.w_ready = 1'b1;
    end
    drain();
    verify_table(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // abc block: inputs W0..W15, then the first two generated words
    for (int i = 0; i < 16; i++) begin
      vecs[i].is_in = 1'b1;
      vecs[i].idx   = i;
      vecs[i].msg   = (i == 0) ? 32'h61626380 : (i == 15) ? 32'h00000018 : 32'h0;
      vecs[i].w     = vecs[i].msg;
    end
    vecs[16].is_in = 1'b0; vecs[16].msg = 32'h0; vecs[16].idx = 16; vecs[16].w = 32'h61626380;
    vecs[17].is_in = 1'b0; vecs[17].msg = 32'h0; vecs[17].idx = 17; vecs[17].w = 32'h000F0000;
    for (int i = 0; i < 18; i++) if (vecs[i].is_in) abc[vecs[i].idx] = vecs[i].msg;
    for (int i = 0; i < 16; i++) blk2[i] = $urandom;

    bus.msg_valid = 1'b0;
    bus.msg_word  = 32'h0;
    bus.w_ready   = 1'b1;

    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check_reset_vals("reset");
    @(posedge CLK); #1;

    run_abc("abc_serial", 0, 1'b0);
    run_abc("abc_backpressure", 0, 1'b1);
    run_abc("abc_gapped", 2, 1'b0);

    expect_block(abc);
    send_words(abc, 0, 7, 0);
    pulse_reset("rst_mid_load");
    run_abc("after_load_rst", 0, 1'b0);

    expect_block(abc);
    send_words(abc, 0, 16, 0);
    wait_index(29);
    @(posedge CLK); #1;
    pulse_reset("rst_mid_emit");
    run_abc("after_emit_rst", 0, 1'b0);

    clear_cap();
    expect_block(abc);
    expect_block(blk2);
    send_words(abc, 0, 16, 0);
    send_words(blk2, 0, 16, 0);
    drain();
    check("b2b_gap_cycles", 32'(gap_meas), 32'd17);
    check("b2b_second_W0", cap[0], blk2[0]);

`ifdef SHA256_W_PARALLEL_LOAD_EN
    clear_cap();
    expect_block(abc);
    for (int i = 0; i < 16; i++) block_in[511 - 32*i -: 32] = abc[i];
    block_load    = 1'b1;
    bus.msg_valid = 1'b1;
    bus.msg_word  = 32'hDEADBEEF;
    @(negedge CLK);
    check_bit("pl_msg_ready", bus.msg_ready, 1'b0);
    check_bit("pl_w_valid_before", bus.w_valid, 1'b0);
    @(posedge CLK); #1;
    block_load    = 1'b0;
    bus.msg_valid = 1'b0;
    @(negedge CLK);
    check_bit("pl_w_valid", bus.w_valid, 1'b1);
    check("pl_W0", bus.w_data, 32'h61626380);
    drain();
    verify_table("parallel");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
